idli_sqi_resp_m: RTL and testbench

//  Synthesizable SQI (quad-SPI) SRAM responder: the far end of the idli SQI memory

---
 rtl/idli_pkg.sv | 30 +++
 rtl/idli_sqi_resp_mem_m.sv | 46 ++++
 rtl/idli_sqi_resp_m.sv | 231 +++++++++++++++++++++++
 tb/tb_idli_sqi_resp_m.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// ----------------------------------------------------------------------------
// idli_pkg
// Shared types and constants for the idli SQI memory path.
//   sqi_resp_state_t  : responder FSM states
//   SQI_CMD_WRITE     : sequential write command byte
//   SQI_CMD_READ      : sequential read command byte
//   SQI_DUMMY_NIBBLES : turnaround nibbles between address and read data
//   sqi_addr_next()   : 16-bit address increment, wraps 0xFFFF -> 0x0000
// ----------------------------------------------------------------------------
package idli_pkg;

   typedef enum logic [2:0] {
      SQI_RESP_IDLE    = 3'd0,
      SQI_RESP_CMD     = 3'd1,
      SQI_RESP_ADDR    = 3'd2,
      SQI_RESP_DUMMY   = 3'd3,
      SQI_RESP_RD_DATA = 3'd4,
      SQI_RESP_WR_DATA = 3'd5,
      SQI_RESP_ERR     = 3'd6
   } sqi_resp_state_t;

   localparam logic [7:0] SQI_CMD_WRITE     = 8'h02;
   localparam logic [7:0] SQI_CMD_READ      = 8'h03;
   localparam logic [1:0] SQI_DUMMY_NIBBLES = 2'd2;

   function automatic logic [15:0] sqi_addr_next(input logic [15:0] addr);
      return addr + 16'd1;
   endfunction

endpackage

// File: rtl/idli_sqi_resp_mem_m.sv
// ----------------------------------------------------------------------------
// idli_sqi_resp_mem_m
// DEPTH x 8 byte store for the SQI responder: one write port, one read port
// with a single-cycle registered read. Array contents are never reset.
//   gck      in   system clock
//   rst      in   async active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_idx   in   write byte index
//   wr_data  in   write byte
//   rd_en    in   read strobe; rd_data updates on the next edge
//   rd_idx   in   read byte index
//   rd_data  out  registered read byte, held between reads
// ----------------------------------------------------------------------------
module idli_sqi_resp_mem_m #(
   parameter  int DEPTH = 256,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             gck,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_data
);

   logic [7:0] mem_r [DEPTH];

   // Storage write port.
   always_ff @(posedge gck) begin
      if (wr_en) begin
         mem_r[wr_idx] <= wr_data;
      end
   end

   // Registered read port; the byte is held until the next read strobe.
   always_ff @(posedge gck or posedge rst) begin
      if (rst) begin
         rd_data <= 8'h00;
      end else if (rd_en) begin
         rd_data <= mem_r[rd_idx];
      end
   end

endmodule

// File: rtl/idli_sqi_resp_m.sv
// ----------------------------------------------------------------------------
// idli_sqi_resp_m
// SQI (quad-SPI) SRAM responder. Oversamples CS/SCK/SIO with the system clock,
// decodes command / 16-bit address / dummy / sequential data nibbles and
// services reads and writes from an internal byte array.
//   i_sresp_gck      in   system clock
//   i_sresp_rst      in   async active-high reset
//   i_sresp_cs_n     in   chip select, active-low
//   i_sresp_sck      in   SQI serial clock
//   i_sresp_sio      in   SQI data from initiator
//   o_sresp_sio      out  SQI data to initiator (changes after SCK falls)
//   o_sresp_sio_oe   out  responder drives SIO, only in RD_DATA
//   o_sresp_busy     out  FSM not idle
//   o_sresp_bad_cmd  out  sticky unsupported-command flag, cleared by reset
// ----------------------------------------------------------------------------
module idli_sqi_resp_m
   import idli_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic       i_sresp_gck,
   input  logic       i_sresp_rst,
   input  logic       i_sresp_cs_n,
   input  logic       i_sresp_sck,
   input  logic [3:0] i_sresp_sio,
   output logic [3:0] o_sresp_sio,
   output logic       o_sresp_sio_oe,
   output logic       o_sresp_busy,
   output logic       o_sresp_bad_cmd
);

   sqi_resp_state_t state_r, state_nxt_s;
   logic        cs_q, sck_q;
   logic [3:0]  sio_q;
   logic        rise_s, fall_s;
   logic [1:0]  nib_q;
   logic [15:0] addr_q;
   logic [3:0]  cmd_hi_r, wr_hi_r;
   logic [7:0]  wr_data_r, rd_data_s, cmd_byte_s;
   logic        is_rd_r, wr_req_r, rd_req_r, cmd_ok_s;
   logic [3:0]  sio_nxt_s;
   logic        oe_nxt_s, bad_cmd_nxt_s;

   // Edges compare the live SCK against its registered copy, so a nibble is
   // taken from sio_q (SIO as seen one cycle before the edge).
   assign rise_s     = i_sresp_sck & ~sck_q;
   assign fall_s     = ~i_sresp_sck & sck_q;
   assign cmd_byte_s = {cmd_hi_r, sio_q};
   assign cmd_ok_s   = (cmd_byte_s == SQI_CMD_WRITE) || (cmd_byte_s == SQI_CMD_READ);

   idli_sqi_resp_mem_m #(.DEPTH(DEPTH)) u_mem (
      .gck     (i_sresp_gck),
      .rst     (i_sresp_rst),
      .wr_en   (wr_req_r),
      .wr_idx  (addr_q[IDX_W-1:0]),
      .wr_data (wr_data_r),
      .rd_en   (rd_req_r),
      .rd_idx  (addr_q[IDX_W-1:0]),
      .rd_data (rd_data_s)
   );

   // Input sampling registers.
   always_ff @(posedge i_sresp_gck or posedge i_sresp_rst) begin
      if (i_sresp_rst) begin
         cs_q  <= 1'b1;
         sck_q <= 1'b0;
         sio_q <= 4'h0;
      end else begin
         cs_q  <= i_sresp_cs_n;
         sck_q <= i_sresp_sck;
         sio_q <= i_sresp_sio;
      end
   end

   // FSM state register.
   always_ff @(posedge i_sresp_gck or posedge i_sresp_rst) begin
      if (i_sresp_rst) begin
         state_r <= SQI_RESP_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; a deselect overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      if (cs_q) begin
         state_nxt_s = SQI_RESP_IDLE;
      end else begin
         case (state_r)
            SQI_RESP_IDLE: state_nxt_s = SQI_RESP_CMD;
            SQI_RESP_CMD: begin
               if (rise_s && (nib_q == 2'd1)) begin
                  state_nxt_s = cmd_ok_s ? SQI_RESP_ADDR : SQI_RESP_ERR;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            SQI_RESP_ADDR: begin
               if (rise_s && (nib_q == 2'd3)) begin
                  state_nxt_s = is_rd_r ? SQI_RESP_DUMMY : SQI_RESP_WR_DATA;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            SQI_RESP_DUMMY: begin
               if (rise_s && (nib_q == (SQI_DUMMY_NIBBLES - 2'd1))) begin
                  state_nxt_s = SQI_RESP_RD_DATA;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            SQI_RESP_RD_DATA, SQI_RESP_WR_DATA, SQI_RESP_ERR: state_nxt_s = state_r;
            default: state_nxt_s = SQI_RESP_IDLE;
         endcase
      end
   end

   // FSM outputs: next values of the registered SIO/OE/bad_cmd.
   always_comb begin
      sio_nxt_s     = o_sresp_sio;
      oe_nxt_s      = o_sresp_sio_oe;
      bad_cmd_nxt_s = o_sresp_bad_cmd;
      if (cs_q) begin
         oe_nxt_s = 1'b0;
      end else if (state_r == SQI_RESP_RD_DATA) begin
         if (fall_s) begin
            oe_nxt_s  = 1'b1;
            sio_nxt_s = nib_q[0] ? rd_data_s[3:0] : rd_data_s[7:4];
         end else begin
            oe_nxt_s  = o_sresp_sio_oe;
         end
      end else begin
         oe_nxt_s = 1'b0;
         if ((state_r == SQI_RESP_CMD) && rise_s && (nib_q == 2'd1) && !cmd_ok_s) begin
            bad_cmd_nxt_s = 1'b1;
         end else begin
            bad_cmd_nxt_s = o_sresp_bad_cmd;
         end
      end
   end

   // Output registers.
   always_ff @(posedge i_sresp_gck or posedge i_sresp_rst) begin
      if (i_sresp_rst) begin
         o_sresp_sio     <= 4'h0;
         o_sresp_sio_oe  <= 1'b0;
         o_sresp_busy    <= 1'b0;
         o_sresp_bad_cmd <= 1'b0;
      end else begin
         o_sresp_sio     <= sio_nxt_s;
         o_sresp_sio_oe  <= oe_nxt_s;
         o_sresp_busy    <= (state_nxt_s != SQI_RESP_IDLE);
         o_sresp_bad_cmd <= bad_cmd_nxt_s;
      end
   end

   // Field capture, address counter and memory strobes. Memory accesses are
   // issued the cycle after the triggering SCK edge, using the settled addr_q.
   always_ff @(posedge i_sresp_gck or posedge i_sresp_rst) begin
      if (i_sresp_rst) begin
         nib_q     <= 2'd0;
         addr_q    <= 16'h0000;
         cmd_hi_r  <= 4'h0;
         wr_hi_r   <= 4'h0;
         wr_data_r <= 8'h00;
         is_rd_r   <= 1'b0;
         wr_req_r  <= 1'b0;
         rd_req_r  <= 1'b0;
      end else begin
         wr_req_r <= 1'b0;
         rd_req_r <= 1'b0;
         if (wr_req_r) begin
            addr_q <= sqi_addr_next(addr_q);
         end
         if (cs_q) begin
            nib_q <= 2'd0;
         end else begin
            case (state_r)
               SQI_RESP_IDLE: nib_q <= 2'd0;
               SQI_RESP_CMD: begin
                  if (rise_s) begin
                     cmd_hi_r <= sio_q;
                     nib_q    <= {1'b0, ~nib_q[0]};
                     if (nib_q[0]) begin
                        is_rd_r <= (cmd_byte_s == SQI_CMD_READ);
                     end
                  end
               end
               SQI_RESP_ADDR: begin
                  if (rise_s) begin
                     addr_q <= {addr_q[11:0], sio_q};
                     nib_q  <= nib_q + 2'd1;
                     if ((nib_q == 2'd3) && is_rd_r) begin
                        rd_req_r <= 1'b1;
                     end
                  end
               end
               SQI_RESP_DUMMY: begin
                  if (rise_s) begin
                     nib_q <= (nib_q == (SQI_DUMMY_NIBBLES - 2'd1)) ? 2'd0 : nib_q + 2'd1;
                  end
               end
               SQI_RESP_RD_DATA: begin
                  if (fall_s) begin
                     nib_q <= {1'b0, ~nib_q[0]};
                     if (nib_q[0]) begin
                        addr_q   <= sqi_addr_next(addr_q);
                        rd_req_r <= 1'b1;
                     end
                  end
               end
               SQI_RESP_WR_DATA: begin
                  if (rise_s) begin
                     nib_q <= {1'b0, ~nib_q[0]};
                     if (nib_q[0]) begin
                        wr_data_r <= {wr_hi_r, sio_q};
                        wr_req_r  <= 1'b1;
                     end else begin
                        wr_hi_r <= sio_q;
                     end
                  end
               end
               default: nib_q <= 2'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// ----------------------------------------------------------------------------
// tb_idli_sqi_resp_m
// Directed SQI transactions against idli_sqi_resp_m at gck:sck = 4:1.
// Stimulus queues expected read nibbles and status expectations; a monitor
// running on the falling gck edge pops and compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_idli_sqi_resp_m;
   import idli_pkg::*;

   typedef struct {
      int         kind;   // 0 oe, 1 busy, 2 bad_cmd, 3 sio, 4 pending read nibbles
      logic [7:0] exp;
      string      name;
   } chk_t;

   logic       gck = 1'b0;
   logic       rst = 1'b1;
   logic       cs_n = 1'b1;
   logic       sck = 1'b0;
   logic [3:0] sio = 4'h0;
   logic [3:0] sio_o;
   logic       oe, busy, bad_cmd;

   logic [3:0] dq[$];
   chk_t       stq[$];
   int         total = 0;
   int         bad = 0;
   logic       sck_prev = 1'b0;
   logic [3:0] mon_e;
   chk_t       mon_c;
   logic [7:0] mon_act;

   idli_sqi_resp_m #(.DEPTH(256)) dut (
      .i_sresp_gck     (gck),
      .i_sresp_rst     (rst),
      .i_sresp_cs_n    (cs_n),
      .i_sresp_sck     (sck),
      .i_sresp_sio     (sio),
      .o_sresp_sio     (sio_o),
      .o_sresp_sio_oe  (oe),
      .o_sresp_busy    (busy),
      .o_sresp_bad_cmd (bad_cmd)
   );

   always #5 gck = ~gck;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   // Monitor: a data nibble is presented whenever SCK rises with oe high.
   always @(negedge gck) begin
      if (sck && !sck_prev && oe) begin
         total++;
         if (dq.size() == 0) begin
            bad++;
            $display("FAIL sio_unexpected: oe=1 sio=%h while no nibble expected", sio_o);
         end else begin
            mon_e = dq.pop_front();
            if (sio_o !== mon_e) begin
               bad++;
               $display("FAIL sio_data: got %h want %h", sio_o, mon_e);
            end
         end
      end
      sck_prev <= sck;
      while (stq.size() > 0) begin
         mon_c = stq.pop_front();
         case (mon_c.kind)
            0:       mon_act = {7'd0, oe};
            1:       mon_act = {7'd0, busy};
            2:       mon_act = {7'd0, bad_cmd};
            3:       mon_act = {4'd0, sio_o};
            default: mon_act = 8'(dq.size());
         endcase
         total++;
         if (mon_act !== mon_c.exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", mon_c.name, mon_act, mon_c.exp);
         end
      end
   end

   task automatic tick();
      @(posedge gck);
      #1;
   endtask

   task automatic st(input int k, input logic [7:0] e, input string n);
      chk_t c;
      c.kind = k;
      c.exp  = e;
      c.name = n;
      stq.push_back(c);
   endtask

   task automatic cs_lo();
      cs_n = 1'b0;
      tick();
      tick();
   endtask

   task automatic cs_hi();
      tick();
      tick();
      cs_n = 1'b1;
      repeat (4) tick();
   endtask

   // One SCK period: low phase 2 gck with data set up, high phase 2 gck.
   task automatic nib(input logic [3:0] n);
      sio = n;
      tick();
      tick();
      sck = 1'b1;
      tick();
      tick();
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      nib(b[7:4]);
      nib(b[3:0]);
   endtask

   task automatic hdr(input logic [7:0] cmd, input logic [15:0] a);
      send_byte(cmd);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic wr(input logic [15:0] a, input int n,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bb [3];
      bb[0] = b0; bb[1] = b1; bb[2] = b2;
      cs_lo();
      hdr(SQI_CMD_WRITE, a);
      st(1, 8'd1, "busy_mid_write");
      for (int i = 0; i < n; i++) send_byte(bb[i]);
      cs_hi();
      st(1, 8'd0, "busy_after_write");
   endtask

   task automatic rd(input logic [15:0] a, input int n,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bb [3];
      bb[0] = b0; bb[1] = b1; bb[2] = b2;
      cs_lo();
      hdr(SQI_CMD_READ, a);
      nib(4'h0);
      nib(4'h0);
      st(0, 8'd0, "oe_before_data");
      for (int i = 0; i < n; i++) begin
         dq.push_back(bb[i][7:4]);
         nib(4'h0);
         dq.push_back(bb[i][3:0]);
         nib(4'h0);
      end
      st(0, 8'd1, "oe_until_cs");
      cs_hi();
      st(4, 8'd0, "read_nibbles_all_seen");
      st(0, 8'd0, "oe_off_after_cs");
      st(1, 8'd0, "busy_after_read");
   endtask

   initial begin
      repeat (3) tick();
      st(0, 8'd0, "rst_oe");
      st(1, 8'd0, "rst_busy");
      st(2, 8'd0, "rst_bad_cmd");
      st(3, 8'd0, "rst_sio");
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // 1: basic write then read back
      wr(16'h1234, 1, 8'hA5, 8'h00, 8'h00);
      rd(16'h1234, 1, 8'hA5, 8'h00, 8'h00);

      // 2: sequential write across the index wrap
      wr(16'h00FE, 3, 8'h11, 8'h22, 8'h33);
      rd(16'h00FE, 3, 8'h11, 8'h22, 8'h33);
      rd(16'h0000, 1, 8'h33, 8'h00, 8'h00);

      // 3: unsupported command, traffic ignored, flag sticky
      cs_lo();
      send_byte(8'h05);
      st(2, 8'd1, "bad_cmd_set");
      repeat (16) nib(4'hF);
      st(0, 8'd0, "oe_in_err");
      st(1, 8'd1, "busy_in_err");
      cs_hi();
      rd(16'h1234, 1, 8'hA5, 8'h00, 8'h00);
      st(2, 8'd1, "bad_cmd_sticky");

      // 4: abort in the address phase, then a clean write
      cs_lo();
      send_byte(SQI_CMD_WRITE);
      nib(4'h0);
      nib(4'h0);
      cs_hi();
      wr(16'h0010, 1, 8'h7E, 8'h00, 8'h00);
      rd(16'h0010, 1, 8'h7E, 8'h00, 8'h00);
      rd(16'h00FE, 3, 8'h11, 8'h22, 8'h33);

      // 5: half a data byte then deselect leaves the target unchanged
      cs_lo();
      hdr(SQI_CMD_WRITE, 16'h1234);
      nib(4'hF);
      cs_hi();
      rd(16'h1234, 1, 8'hA5, 8'h00, 8'h00);

      // 6: reset in the middle of read data
      cs_lo();
      hdr(SQI_CMD_READ, 16'h00FE);
      nib(4'h0);
      nib(4'h0);
      dq.push_back(4'h1);
      nib(4'h0);
      dq.push_back(4'h1);
      nib(4'h0);
      sio = 4'h0;
      tick();
      tick();
      st(0, 8'd1, "oe_before_rst");
      tick();
      rst  = 1'b1;
      cs_n = 1'b1;
      st(0, 8'd0, "oe_async_rst");
      st(1, 8'd0, "busy_async_rst");
      st(2, 8'd0, "bad_cmd_cleared");
      st(4, 8'd0, "nibbles_before_rst");
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      rd(16'h00FE, 3, 8'h11, 8'h22, 8'h33);
      rd(16'h0010, 1, 8'h7E, 8'h00, 8'h00);

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
